// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: line-locked round-robin arbiter sharing one UART TX byte channel; optional stall timeout via UART_ARB_TIMEOUT_EN
module uart_tx_arbiter #(
    parameter int         N        = 4,
    parameter int         MAXBURST = 80,
    parameter logic [7:0] EOL      = 8'h0a,
    parameter int         TIMEOUT  = 1024
) (
    input  logic           clk,
    input  logic           nreset,
    input  logic [N-1:0]   req_valid,
    input  logic [8*N-1:0] req_data,
    output logic [N-1:0]   req_ready,
    output logic           out_valid,
    output logic [7:0]     out_data,
    input  logic           out_ready,
    output logic [N-1:0]   grant,
    output logic           busy
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int BW = $clog2(MAXBURST + 1);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t        state;
    logic [IW-1:0] rr;
    logic [IW-1:0] owner;
    logic [IW-1:0] sel;
    logic          found;
    logic [BW-1:0] burst_cnt;
    logic [BW-1:0] burst_nxt;
    logic          xfer;
    logic          line_done;
    logic          timeout;

    if (N < 1 || N > 16 || MAXBURST < 1 || TIMEOUT < 1) begin : g_bad_params
        $error("uart_tx_arbiter: parameter out of range");
    end

    // first valid requester at or after the rr pointer, wrapping
    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && req_valid[(int'(rr) + k) % N]) begin
                found = 1'b1;
                sel   = IW'((int'(rr) + k) % N);
            end
        end
    end

    assign busy      = (state == LOCKED);
    assign out_valid = |(grant & req_valid);
    assign out_data  = busy ? req_data[8*owner +: 8] : 8'h00;
    assign req_ready = grant & {N{out_ready}};
    assign xfer      = out_valid & out_ready;
    assign burst_nxt = (burst_cnt == BW'(MAXBURST)) ? burst_cnt : burst_cnt + 1'b1;
    assign line_done = xfer && (out_data == EOL || burst_nxt == BW'(MAXBURST));

`ifdef UART_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] idle_cnt;

    // release fires on the cycle the idle count would reach TIMEOUT
    assign timeout = !out_valid && (idle_cnt == TW'(TIMEOUT - 1));
`else
    assign timeout = 1'b0;
`endif

    // grant FSM: pick owner in IDLE, hold it until end of line, burst limit or stall timeout
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state     <= IDLE;
            grant     <= '0;
            rr        <= '0;
            owner     <= '0;
            burst_cnt <= '0;
`ifdef UART_ARB_TIMEOUT_EN
            idle_cnt  <= '0;
`endif
        end else if (state == IDLE) begin
            if (found) begin
                state     <= LOCKED;
                grant     <= N'(1) << sel;
                owner     <= sel;
                burst_cnt <= '0;
`ifdef UART_ARB_TIMEOUT_EN
                idle_cnt  <= '0;
`endif
            end
        end else if (line_done || timeout) begin
            state <= IDLE;
            grant <= '0;
            rr    <= IW'((int'(owner) + 1) % N);
        end else begin
            if (xfer)
                burst_cnt <= burst_nxt;
`ifdef UART_ARB_TIMEOUT_EN
            if (xfer)
                idle_cnt <= '0;
            else if (!out_valid && idle_cnt != TW'(TIMEOUT))
                idle_cnt <= idle_cnt + 1'b1;
`endif
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: randomized and directed checks of uart_tx_arbiter against a line-level reference model
module tb_uart_tx_arbiter;
    localparam int         N    = 4;
    localparam int         MAXB = 4;
    localparam int         TMO  = 16;
    localparam logic [7:0] EOLB = 8'h0a;

    logic           clk = 1'b0;
    logic           nreset = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   req_ready;
    logic           out_valid;
    logic [7:0]     out_data;
    logic           out_ready = 1'b0;
    logic [N-1:0]   grant;
    logic           busy;

    logic [7:0] q [N][$];
    logic [7:0] obs [$];
    int n_cmp = 0;
    int n_bad = 0;
    logic s_valid, s_busy, s_xfer;
    logic [7:0] s_data;
    logic [N-1:0] s_grant, s_ready, s_reqv;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.N(N), .MAXBURST(MAXB), .EOL(EOLB), .TIMEOUT(TMO)) dut (
        .clk(clk), .nreset(nreset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .grant(grant), .busy(busy)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]      = q[i].size() > 0;
            req_data[8*i +: 8] = (q[i].size() > 0) ? q[i][0] : 8'h00;
        end
    endtask

    // one clock: drive requesters, sample at negedge, requesters pop on handshake
    task automatic cycle();
        drive();
        @(negedge clk);
        s_valid = out_valid;
        s_data  = out_data;
        s_grant = grant;
        s_ready = req_ready;
        s_busy  = busy;
        s_reqv  = req_valid;
        s_xfer  = out_valid && out_ready;
        if (s_xfer) obs.push_back(out_data);
        for (int i = 0; i < N; i++)
            if (req_valid[i] && req_ready[i]) void'(q[i].pop_front());
        @(posedge clk);
        #1;
    endtask

    task automatic push_str(input int i, input string s);
        for (int k = 0; k < s.len(); k++) q[i].push_back(s[k]);
    endtask

    task automatic do_reset();
        for (int i = 0; i < N; i++) q[i].delete();
        obs.delete();
        drive();
        out_ready = 1'b0;
        nreset = 1'b0;
        #3;
        nreset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // expected transfers derived from queues: round-robin owner, chunk ends on EOL or MAXB bytes
    task automatic run_model(input string name, input int ready_pct);
        logic [7:0] mq [N][$];
        logic [7:0] eb [$];
        int eo [$];
        bit el [$];
        int rr, g, cnt, cyc;
        bit stop, pl, pstall, preq;
        logic [7:0] b, pd;
        logic [N-1:0] pg;
        for (int i = 0; i < N; i++) mq[i] = q[i];
        rr = 0;
        forever begin
            g = -1;
            for (int k = 0; k < N; k++)
                if (g < 0 && mq[(rr + k) % N].size() > 0) g = (rr + k) % N;
            if (g < 0) break;
            cnt = 0;
            stop = 0;
            while (mq[g].size() > 0 && !stop) begin
                b = mq[g].pop_front();
                cnt++;
                stop = (b == EOLB) || (cnt == MAXB);
                eb.push_back(b);
                eo.push_back(g);
                el.push_back(stop);
            end
            rr = (g + 1) % N;
        end
        pg = '0; pl = 0; pstall = 0; preq = 0; pd = 8'h00; cyc = 0;
        while (eb.size() > 0 && cyc < 3000) begin
            out_ready = ($urandom_range(99) < ready_pct);
            cycle();
            cyc++;
            n_cmp++;
            if (s_ready !== (s_grant & {N{out_ready}})) begin
                n_bad++;
                $display("FAIL %s req_ready: got %b want %b", name, s_ready, s_grant & {N{out_ready}});
            end
            if (pg != '0) begin
                n_cmp++;
                if (s_grant !== (pl ? '0 : pg)) begin
                    n_bad++;
                    $display("FAIL %s grant_hold: got %b want %b", name, s_grant, pl ? '0 : pg);
                end
                if (pstall && !pl) begin
                    n_cmp++;
                    if (s_data !== pd) begin
                        n_bad++;
                        $display("FAIL %s stall_data: got %h want %h", name, s_data, pd);
                    end
                end
            end else if (preq) begin
                n_cmp++;
                if (s_grant === '0) begin
                    n_bad++;
                    $display("FAIL %s bubble: got grant %b want nonzero", name, s_grant);
                end
            end
            pl = 0;
            if (s_xfer) begin
                n_cmp++;
                if ({s_grant, s_data} !== {N'(1) << eo[0], eb[0]}) begin
                    n_bad++;
                    $display("FAIL %s xfer: got grant %b data %h want grant %b data %h",
                             name, s_grant, s_data, N'(1) << eo[0], eb[0]);
                end
                pl = el[0];
                void'(eb.pop_front());
                void'(eo.pop_front());
                void'(el.pop_front());
            end
            pg = s_grant;
            pstall = s_valid && !out_ready;
            pd = s_data;
            preq = |s_reqv;
        end
        n_cmp++;
        if (eb.size() != 0) begin
            n_bad++;
            $display("FAIL %s timeout: got %0d bytes left want 0", name, eb.size());
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < N; i++) q[i].push_back(8'h55);
        drive();
        out_ready = 1'b1;
        nreset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({grant, busy, out_valid, out_data, req_ready} !== '0) begin
            n_bad++;
            $display("FAIL reset_held: got grant=%b busy=%b valid=%b data=%h ready=%b want all 0",
                     grant, busy, out_valid, out_data, req_ready);
        end
        for (int i = 0; i < N; i++) q[i].delete();
        drive();
        @(posedge clk);
        #1;
        nreset = 1'b1;
        cycle();
        n_cmp++;
        if ({s_grant, s_busy, s_valid, s_data, s_ready} !== '0) begin
            n_bad++;
            $display("FAIL reset_idle: got grant=%b busy=%b valid=%b data=%h ready=%b want all 0",
                     s_grant, s_busy, s_valid, s_data, s_ready);
        end
    endtask

    task automatic test_hi();
        logic [12:0] exp [5];
        exp = '{{4'b0000, 1'b0, 8'h00}, {4'b0001, 1'b1, 8'h68}, {4'b0001, 1'b1, 8'h69},
                {4'b0001, 1'b1, 8'h0a}, {4'b0000, 1'b0, 8'h00}};
        do_reset();
        push_str(0, "hi\n");
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            cycle();
            n_cmp++;
            if ({s_grant, s_valid, s_data} !== exp[c]) begin
                n_bad++;
                $display("FAIL hi_c%0d: got grant=%b valid=%b data=%h want %h", c, s_grant, s_valid, s_data, exp[c]);
            end
        end
        n_cmp++;
        if (s_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL hi_busy: got %b want 0", s_busy);
        end
    endtask

    task automatic test_two_lines();
        do_reset();
        push_str(0, "AB\n");
        push_str(1, "CD\n");
        run_model("two_lines", 100);
    endtask

    task automatic test_rr();
        logic [N-1:0] exp [10];
        exp = '{4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
        do_reset();
        for (int i = 0; i < N; i++) begin
            q[i].push_back(EOLB);
            q[i].push_back(EOLB);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            cycle();
            n_cmp++;
            if (s_grant !== exp[c]) begin
                n_bad++;
                $display("FAIL rr_c%0d: got grant %b want %b", c, s_grant, exp[c]);
            end
        end
    endtask

    task automatic test_burst();
        logic [7:0] exp [8];
        exp = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h5a, 8'h0a, 8'h05, 8'h06};
        do_reset();
        for (int b = 1; b <= 6; b++) q[1].push_back(8'(b));
        push_str(2, "Z\n");
        run_model("burst", 60);
        n_cmp++;
        if (obs.size() != 8) begin
            n_bad++;
            $display("FAIL burst_count: got %0d bytes want 8", obs.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                n_cmp++;
                if (obs[k] !== exp[k]) begin
                    n_bad++;
                    $display("FAIL burst_b%0d: got %h want %h", k, obs[k], exp[k]);
                end
            end
        end
    endtask

    task automatic test_stall_reset();
        int c;
        do_reset();
        push_str(0, "X\n");
        q[1] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h0a};
        out_ready = 1'b1;
        c = 0;
        do begin
            cycle();
            c++;
        end while (!(s_xfer && s_data == 8'h22) && c < 30);
        n_cmp++;
        if (c >= 30) begin
            n_bad++;
            $display("FAIL stall_reach: got no 22 transfer in %0d cycles want one", c);
        end
        out_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cycle();
            n_cmp++;
            if ({s_grant, s_valid, s_data, s_ready} !== {4'b0010, 1'b1, 8'h33, 4'b0000}) begin
                n_bad++;
                $display("FAIL stall_k%0d: got grant=%b valid=%b data=%h ready=%b want 0010 1 33 0000",
                         k, s_grant, s_valid, s_data, s_ready);
            end
        end
        out_ready = 1'b1;
        cycle();
        n_cmp++;
        if ({s_xfer, s_data} !== {1'b1, 8'h33}) begin
            n_bad++;
            $display("FAIL stall_resume: got xfer=%b data=%h want 1 33", s_xfer, s_data);
        end
        cycle();
        n_cmp++;
        if ({s_xfer, s_data} !== {1'b1, 8'h44}) begin
            n_bad++;
            $display("FAIL stall_nodup: got xfer=%b data=%h want 1 44", s_xfer, s_data);
        end
        nreset = 1'b0;
        #2;
        n_cmp++;
        if ({grant, busy, out_valid, out_data, req_ready} !== '0) begin
            n_bad++;
            $display("FAIL midline_reset: got grant=%b busy=%b valid=%b data=%h ready=%b want all 0",
                     grant, busy, out_valid, out_data, req_ready);
        end
        nreset = 1'b1;
        for (int i = 0; i < N; i++) q[i].delete();
        push_str(0, "a\n");
        push_str(1, "b\n");
        cycle();
        cycle();
        n_cmp++;
        if (s_grant !== 4'b0001) begin
            n_bad++;
            $display("FAIL rr_after_reset: got grant %b want 0001", s_grant);
        end
    endtask

    task automatic test_owner_stall();
        do_reset();
        push_str(0, "A");
        push_str(3, "Z\n");
        out_ready = 1'b1;
        cycle();
        cycle();
        n_cmp++;
        if ({s_xfer, s_grant, s_data} !== {1'b1, 4'b0001, 8'h41}) begin
            n_bad++;
            $display("FAIL owner_first: got xfer=%b grant=%b data=%h want 1 0001 41", s_xfer, s_grant, s_data);
        end
`ifdef UART_ARB_TIMEOUT_EN
        for (int c = 2; c < 20; c++) begin
            cycle();
            n_cmp++;
            if (s_grant !== ((c <= 17) ? 4'b0001 : (c == 18) ? 4'b0000 : 4'b1000)) begin
                n_bad++;
                $display("FAIL timeout_c%0d: got grant %b want %b", c, s_grant,
                         (c <= 17) ? 4'b0001 : (c == 18) ? 4'b0000 : 4'b1000);
            end
        end
`else
        for (int c = 2; c < 42; c++) begin
            cycle();
            n_cmp++;
            if ({s_grant, s_valid, s_ready} !== {4'b0001, 1'b0, 4'b0001}) begin
                n_bad++;
                $display("FAIL owner_hold_c%0d: got grant=%b valid=%b ready=%b want 0001 0 0001",
                         c, s_grant, s_valid, s_ready);
            end
        end
`endif
    endtask

    task automatic test_random();
        int len;
        for (int r = 0; r < 4; r++) begin
            do_reset();
            for (int i = 0; i < N; i++) begin
                len = $urandom_range(7);
                for (int j = 0; j < len - 1; j++)
                    q[i].push_back(($urandom_range(3) == 0) ? EOLB : 8'($urandom_range(8'h7e, 8'h20)));
                if (len > 0) q[i].push_back(EOLB);
            end
            run_model("random", 70);
        end
    endtask

    initial begin
        test_reset();
        test_hi();
        test_two_lines();
        test_rr();
        test_burst();
        test_stall_reset();
        test_owner_stall();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
